// File: rtl/accum_array.sv
// accum_array: multi-lane signed accumulator for the MLP controller.
// Each beat carries LANES signed DATAW-bit partial results that share one
// accumulator address. A beat either overwrites the entry (i_accum=0) or adds
// to it (i_accum=1). Results appear two cycles after the beat. Overflow
// saturates or wraps depending on SAT, and always sets a sticky per-lane flag.
// Back-to-back beats to the same address take the operand from the forwarding
// path instead of the stale memory read.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   i_valid   input beat valid (no backpressure)
//   i_data    LANES x DATAW signed data, lane k at [k*DATAW +: DATAW]
//   i_addr    accumulator entry shared by all lanes
//   i_accum   1 = add to stored value, 0 = overwrite with sign-extended data
//   i_last    last subset of the vector; gates o_valid
//   o_valid   o_result holds a final sum
//   o_result  LANES x ACCW per-lane result, lane k at [k*ACCW +: ACCW]
//   o_ovf     sticky per-lane overflow flags
module accum_array #(
    parameter int LANES = 4,
    parameter int DATAW = 16,
    parameter int ACCW  = 32,
    parameter int DEPTH = 512,
    parameter int ADDRW = $clog2(DEPTH),
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [LANES*DATAW-1:0] i_data,
    input  logic [ADDRW-1:0]       i_addr,
    input  logic                   i_accum,
    input  logic                   i_last,
    output logic                   o_valid,
    output logic [LANES*ACCW-1:0]  o_result,
    output logic [LANES-1:0]       o_ovf
);

    // Stage-1 beat registers
    logic                   s1_valid_q;
    logic [ADDRW-1:0]       s1_addr_q;
    logic [LANES*DATAW-1:0] s1_data_q;
    logic                   s1_accum_q;
    logic                   s1_last_q;
    logic                   fwd_q;      // stage-1 beat follows a same-address beat

    // Memory and its registered read port
    logic [LANES*ACCW-1:0]  mem_q [DEPTH];
    logic [LANES*ACCW-1:0]  rdata_q;

    // Output registers; res_q doubles as the forwarding source
    logic                   valid_q;
    logic [LANES*ACCW-1:0]  res_q;
    logic [LANES-1:0]       ovf_q;

    // Stage-1 combinational results
    logic [LANES*ACCW-1:0]  res_d;
    logic [LANES-1:0]       ovf_d;

    // One lane: returns {overflow, final value}.
    function automatic logic [ACCW:0] lane_calc(
        input logic [DATAW-1:0] data,
        input logic [ACCW-1:0]  operand,
        input logic             accum
    );
        logic [ACCW:0]   sum;
        logic [ACCW-1:0] value;
        logic            ovf;
        sum = {{(ACCW+1-DATAW){data[DATAW-1]}}, data};
        if (accum) begin
            sum = sum + {operand[ACCW-1], operand};
        end
        // The extra top bit disagreeing with the ACCW sign bit means the
        // true sum left the signed ACCW range.
        ovf   = accum && (sum[ACCW] != sum[ACCW-1]);
        value = sum[ACCW-1:0];
        if (ovf && (SAT != 0)) begin
            value = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                              : {1'b0, {(ACCW-1){1'b1}}};
        end
        return {ovf, value};
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and infers a latch.
        res_d = '0;
        ovf_d = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [ACCW-1:0] operand;
            logic [ACCW:0]   r;
            operand = fwd_q ? res_q[k*ACCW +: ACCW] : rdata_q[k*ACCW +: ACCW];
            r = lane_calc(s1_data_q[k*DATAW +: DATAW], operand, s1_accum_q);
            res_d[k*ACCW +: ACCW] = r[ACCW-1:0];
            ovf_d[k]              = r[ACCW];
        end
    end

    // NOTE: the accumulator storage has no reset; software restarts each
    // vector with i_accum=0, so clearing it would only cost area and time.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem_q[s1_addr_q] <= res_d;
        end
        if (i_valid) begin
            rdata_q <= mem_q[i_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_accum_q <= 1'b0;
            s1_last_q  <= 1'b0;
            fwd_q      <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            ovf_q      <= '0;
        end else begin
            s1_valid_q <= i_valid;
            s1_addr_q  <= i_addr;
            s1_data_q  <= i_data;
            s1_accum_q <= i_accum;
            s1_last_q  <= i_last;
            // The memory write of the stage-1 beat lands at this same edge,
            // so an adjacent same-address beat must take res_q instead.
            fwd_q      <= s1_valid_q && i_valid && (s1_addr_q == i_addr);
            valid_q    <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                res_q <= res_d;
            end
            ovf_q      <= ovf_q | (ovf_d & {LANES{s1_valid_q}});
        end
    end

    assign o_valid  = valid_q;
    assign o_result = res_q;
    assign o_ovf    = ovf_q;

endmodule
